// File: rtl/line_buffer_ctrl_pkg.sv
// Shared constants for the Sobel line-buffer sequencer: FSM encodings, buffer count,
// default geometry and the buffer-select decode.
package line_buffer_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int NUM_LB         = 3;
    localparam int IMG_WIDTH_DEF  = 10;
    localparam int IMG_HEIGHT_DEF = 10;
    localparam int COL_W_DEF      = 4;
    localparam int ROW_W_DEF      = 4;

    function automatic logic [NUM_LB-1:0] lb_onehot(input logic [1:0] idx);
        logic [NUM_LB-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_mod3_ptr.sv
// Modulo-3 pointer (0->1->2->0) used for the write buffer and the window-top buffer.
// A synchronous clear wins over the advance so a finished frame restarts at buffer 0.
module mod3_ptr
    import line_buffer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [1:0] ptr_o
);

    localparam logic [1:0] PTR_LAST = 2'(NUM_LB - 1);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = 2'd0;
        end else if (en_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? 2'd0 : ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Raster-stream sequencer for three rotating line buffers feeding a 3x3 Sobel window.
//
// state | meaning
// IDLE  | waiting for start_i, stream not accepted
// FILL  | writing rows 0 and 1, no complete window possible yet
// RUN   | writing rows 2.., buffers read and top row rotates at each line end
// DONE  | one cycle after the last pixel, frame_done_o high
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int COL_W      = COL_W_DEF,
    parameter int ROW_W      = ROW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic [NUM_LB-1:0] lb_we_o,
    output logic [1:0]        lb_wsel_o,
    output logic              lb_rd_en_o,
    output logic [1:0]        top_sel_o,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              win_valid_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILL = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(2);

    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_out_q;
    logic [ROW_W-1:0] row_out_q;
    logic             win_q;

    logic       accept;
    logic       line_end;
    logic       frame_end;
    logic [1:0] wsel;
    logic [1:0] top_sel;

    assign pix_ready_o = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign accept      = pix_valid_i && pix_ready_o;
    assign line_end    = accept && (col_q == COL_LAST);
    assign frame_end   = line_end && (row_q == ROW_LAST);

    mod3_ptr u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (line_end),
        .clr_i (frame_end),
        .ptr_o (wsel)
    );

    // Top row only advances once three rows are resident, i.e. at line ends in RUN.
    mod3_ptr u_top_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (line_end && (state_q == ST_RUN)),
        .clr_i (frame_end),
        .ptr_o (top_sel)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_FILL;
            ST_FILL: if (line_end && (row_q == ROW_FILL)) state_d = ST_RUN;
            ST_RUN:  if (frame_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            col_out_q <= '0;
            row_out_q <= '0;
            win_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            // Position outputs line up with the 1-cycle buffer read latency.
            if (accept) begin
                col_out_q <= col_q;
                row_out_q <= row_q;
            end
            win_q <= accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
        end
    end

    assign lb_we_o      = accept ? lb_onehot(wsel) : '0;
    assign lb_wsel_o    = wsel;
    assign lb_rd_en_o   = accept && (state_q == ST_RUN);
    assign top_sel_o    = top_sel;
    assign col_o        = col_out_q;
    assign row_o        = row_out_q;
    assign win_valid_o  = win_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: 4x4 frames (continuous, stall, stray start,
// mid-frame reset) plus a 4x6 instance for buffer-role rotation.
module tb_line_buffer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_i = 1'b0, pix_valid_i = 1'b0;
    logic       pix_ready_o, lb_rd_en_o, win_valid_o, busy_o, frame_done_o;
    logic [2:0] lb_we_o;
    logic [1:0] lb_wsel_o, top_sel_o;
    logic [3:0] col_o, row_o;

    logic       b_start = 1'b0, b_valid = 1'b0;
    logic       b_ready, b_rd_en, b_win, b_busy, b_done;
    logic [2:0] b_we;
    logic [1:0] b_wsel, b_top;
    logic [3:0] b_col, b_row;

    line_buffer_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .COL_W(4), .ROW_W(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o), .lb_we_o(lb_we_o), .lb_wsel_o(lb_wsel_o),
        .lb_rd_en_o(lb_rd_en_o), .top_sel_o(top_sel_o), .col_o(col_o), .row_o(row_o),
        .win_valid_o(win_valid_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    line_buffer_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(6), .COL_W(4), .ROW_W(4)) dut_rot (
        .clk(clk), .rst(rst), .start_i(b_start), .pix_valid_i(b_valid),
        .pix_ready_o(b_ready), .lb_we_o(b_we), .lb_wsel_o(b_wsel),
        .lb_rd_en_o(b_rd_en), .top_sel_o(b_top), .col_o(b_col), .row_o(b_row),
        .win_valid_o(b_win), .busy_o(b_busy), .frame_done_o(b_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({pix_ready_o, lb_we_o, lb_wsel_o, lb_rd_en_o, top_sel_o,
                    col_o, row_o, win_valid_o, busy_o, frame_done_o});
    endfunction

    logic [2:0] we_log[$];
    logic [7:0] win_log[$];
    int         done_log[$];
    int         rd_cnt;

    // mode 0 continuous, 1 stall at row1/col2, 2 stray start at row 2, 3 reset at row3/col1
    task automatic run_frame(input int mode);
        we_log.delete();
        win_log.delete();
        done_log.delete();
        rd_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start_i     = (cyc == 0) || (mode == 2 && cyc == 9);
            pix_valid_i = !(mode == 1 && cyc >= 7 && cyc <= 9);
            if (mode == 3 && cyc == 14) rst = 1'b0;
            if (mode == 3 && cyc == 15) rst = 1'b1;
            #1;
            if (mode == 3 && cyc == 14) check_val("reset_mid_frame_outs", all_outs(), 32'd0);
            if (mode == 1 && cyc >= 7 && cyc <= 9) begin
                check_val("stall_we", 32'(lb_we_o), 32'd0);
                check_val("stall_rd_en", 32'(lb_rd_en_o), 32'd0);
                check_val("stall_pos", 32'({row_o, col_o}), 32'h11);
            end
            if (lb_we_o != 3'b000) we_log.push_back(lb_we_o);
            if (win_valid_o) win_log.push_back({row_o, col_o});
            if (frame_done_o) done_log.push_back(cyc);
            if (lb_rd_en_o) rd_cnt++;
        end
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_done);
        logic [7:0] exp_win[4];
        exp_win = '{8'h22, 8'h23, 8'h32, 8'h33};
        check_val({tag, "_we_count"}, 32'(we_log.size()), 32'd16);
        for (int i = 0; i < we_log.size() && i < 16; i++)
            check_val({tag, "_we_seq"}, 32'(we_log[i]), 32'(3'b001 << ((i / 4) % 3)));
        check_val({tag, "_win_count"}, 32'(win_log.size()), 32'd4);
        for (int i = 0; i < win_log.size() && i < 4; i++)
            check_val({tag, "_win_pos"}, 32'(win_log[i]), 32'(exp_win[i]));
        check_val({tag, "_done_count"}, 32'(done_log.size()), 32'd1);
        if (done_log.size() > 0) check_val({tag, "_done_cycle"}, 32'(done_log[0]), 32'(exp_done));
        check_val({tag, "_rd_count"}, 32'(rd_cnt), 32'd8);
        check_val({tag, "_idle_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int exp_top[6];
        int b_acc;
        int b_done_cyc;
        exp_top = '{0, 0, 0, 1, 2, 0};

        #1;
        check_val("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pix_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("idle_ready", 32'(pix_ready_o), 32'd0);
        check_val("idle_busy", 32'(busy_o), 32'd0);
        check_val("idle_we", 32'(lb_we_o), 32'd0);
        pix_valid_i = 1'b0;

        run_frame(0);
        check_frame("cont", 17);

        run_frame(1);
        check_frame("stall", 20);

        run_frame(2);
        check_frame("stray_start", 17);

        run_frame(3);
        check_val("reset_we_count", 32'(we_log.size()), 32'd13);
        check_val("reset_done_count", 32'(done_log.size()), 32'd0);
        check_val("reset_then_idle", 32'(busy_o), 32'd0);

        run_frame(0);
        check_frame("after_reset", 17);

        b_acc = 0;
        b_done_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            b_start = (cyc == 0);
            b_valid = 1'b1;
            #1;
            if (b_we != 3'b000) begin
                if (b_acc % 4 == 0) begin
                    check_val("rot_top_sel", 32'(b_top), 32'(exp_top[b_acc / 4]));
                    check_val("rot_wsel", 32'(b_wsel), 32'((b_acc / 4) % 3));
                end
                b_acc++;
            end
            if (b_done && b_done_cyc < 0) b_done_cyc = cyc;
        end
        b_valid = 1'b0;
        check_val("rot_accepts", 32'(b_acc), 32'd24);
        check_val("rot_done_cycle", 32'(b_done_cyc), 32'd25);
        check_val("rot_wsel_wrapped", 32'(b_wsel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
